// File: rtl/decryption_full.sv
// ---------------------------------------------------------------------------
// decryption_full
//   AES-128 inverse cipher (FIPS-197), fully unrolled combinational datapath
//   followed by a single 128-bit output register. There is no handshake, so a
//   new block can be applied every clock and each result appears one rising
//   edge after its inputs. The round keys arrive already expanded. No key
//   expansion is done here.
//
//   Ports
//     clk        in   1     clock; the output register updates on the rising edge
//     rst        in   1     asynchronous active-high reset; clears plainText
//     key        in   1408  key schedule; round key i = key[1407-128*i -: 128]
//     data       in   128   ciphertext block
//     plainText  out  128   registered plaintext block
//
//   Byte n of any 128-bit block is bits [127-8n -: 8]. The state is
//   column-major, so state[r][c] = byte 4c+r, and each 32-bit chunk is one
//   column with row 0 in its top byte.
// ---------------------------------------------------------------------------
module decryption_full (
    input  logic          clk,
    input  logic          rst,
    input  logic [1407:0] key,
    input  logic [127:0]  data,
    output logic [127:0]  plainText
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Rotate row r right by r bytes. Source byte indices for output bytes
    // 0..15 are 0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        return {s[127:120], s[23:16],   s[47:40],   s[71:64],
                s[95:88],   s[119:112], s[15:8],    s[39:32],
                s[63:56],   s[87:80],   s[111:104], s[7:0],
                s[31:24],   s[55:48],   s[79:72],   s[103:96]};
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[8*n +: 8] = INV_SBOX[s[8*n +: 8]];
        end
        return o;
    endfunction

    // Each output byte takes 0e/0b/0d/09 multiples of the column.
    // x8 ^ x4 ^ x2 = 0e, x8 ^ x2 ^ x = 0b, x8 ^ x4 ^ x = 0d, x8 ^ x = 09.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[32*c +: 32] = inv_mix_column(s[32*c +: 32]);
        end
        return o;
    endfunction

    // One middle round, in the order InvShiftRows, InvSubBytes,
    // AddRoundKey, InvMixColumns.
    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk);
        return inv_mix_columns(inv_sub_bytes(inv_shift_rows(s)) ^ rk);
    endfunction

    // ---- stage p0: unrolled inverse cipher (combinational) ----
    logic [127:0] round_10_p0, round_9_p0, round_8_p0, round_7_p0, round_6_p0;
    logic [127:0] round_5_p0, round_4_p0, round_3_p0, round_2_p0, round_1_p0;
    logic [127:0] plain_p0;

    assign round_10_p0 = data ^ key[127:0];
    assign round_9_p0  = dec_round(round_10_p0, key[255:128]);
    assign round_8_p0  = dec_round(round_9_p0,  key[383:256]);
    assign round_7_p0  = dec_round(round_8_p0,  key[511:384]);
    assign round_6_p0  = dec_round(round_7_p0,  key[639:512]);
    assign round_5_p0  = dec_round(round_6_p0,  key[767:640]);
    assign round_4_p0  = dec_round(round_5_p0,  key[895:768]);
    assign round_3_p0  = dec_round(round_4_p0,  key[1023:896]);
    assign round_2_p0  = dec_round(round_3_p0,  key[1151:1024]);
    assign round_1_p0  = dec_round(round_2_p0,  key[1279:1152]);
    assign plain_p0    = inv_sub_bytes(inv_shift_rows(round_1_p0)) ^ key[1407:1280];

    // ---- stage p1: output register ----
    logic [127:0] plain_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plain_p1 <= '0;
        end else begin
            plain_p1 <= plain_p0;
        end
    end

    assign plainText = plain_p1;

endmodule

// File: tb/tb_decryption_full.sv
// ---------------------------------------------------------------------------
// tb_decryption_full
//   Bench for decryption_full. Inputs are driven on the falling edge. The
//   expected plaintext for each block goes into a queue at drive time. It is
//   popped and compared against plainText on the following falling edge. The
//   known-answer vectors use literal plaintexts. All other expectations come
//   from a software AES model. The model derives its S-box from GF(2^8)
//   inversion plus the affine map, and it expands keys itself.
// ---------------------------------------------------------------------------
module tb_decryption_full;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_DATA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KF_KEY  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] KF_DATA = 128'h29C3505F571420F6402299B31A02D73A;
    localparam logic [127:0] KF_PT   = 128'h54776F204F6E65204E696E652054776F;

    logic           clk = 1'b0;
    logic           rst;
    logic [1407:0]  key;
    logic [127:0]   data;
    logic [127:0]   plainText;

    int vectors     = 0;
    int miscompares = 0;

    logic [127:0]  exp_q [$];
    logic [7:0]    fwd_sbox [256];
    logic [7:0]    inv_sbox [256];
    logic [7:0]    imc [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                  '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                  '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                  '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    logic [1407:0] c1_sched;
    logic [1407:0] kf_sched;

    decryption_full dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .data      (data),
        .plainText (plainText)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    task automatic init_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] xb;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
                end
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            fwd_sbox[x] = s;
            inv_sbox[s] = xb;
        end
    endtask

    function automatic logic [1407:0] expand_key(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] sched;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {fwd_sbox[t[31:24]], fwd_sbox[t[23:16]], fwd_sbox[t[15:8]], fwd_sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        sched = '0;
        for (int i = 0; i < 44; i++) sched[1407-32*i -: 32] = w[i];
        return sched;
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [1407:0] ks, input logic [127:0] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] rk;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127-8*(4*c+r) -: 8] ^ ks[127-8*(4*c+r) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            rk = ks[1407-128*rnd -: 128];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = inv_sbox[s[r][(c+4-r)%4]] ^ rk[127-8*(4*c+r) -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        s[r][c] = gmul(imc[r][0], t[0][c]) ^ gmul(imc[r][1], t[1][c]) ^
                                  gmul(imc[r][2], t[2][c]) ^ gmul(imc[r][3], t[3][c]);
            end else begin
                s = t;
            end
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // Apply one block and queue the plaintext expected one edge later.
    task automatic drive(input logic [1407:0] k, input logic [127:0] d, input logic [127:0] expected);
        key  = k;
        data = d;
        exp_q.push_back(expected);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [127:0] expected;
        repeat (2) @(negedge clk);
        vectors++;
        if (plainText !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", plainText, 128'h0);
        end
        rst = 1'b0;
        drive('0, '0, model_decrypt('0, '0));
        @(negedge clk);
        expected = exp_q.pop_front();
        vectors++;
        if (plainText !== expected) begin
            miscompares++;
            $display("FAIL zero_vector: got %h expected %h", plainText, expected);
        end
    endtask

    task automatic test_fips_c1();
        logic [127:0] expected;
        @(negedge clk);
        drive(c1_sched, C1_DATA, C1_PT);
        @(negedge clk);
        expected = exp_q.pop_front();
        vectors++;
        if (plainText !== expected) begin
            miscompares++;
            $display("FAIL fips_c1: got %h expected %h", plainText, expected);
        end
    endtask

    task automatic test_kung_fu();
        logic [127:0] expected;
        @(negedge clk);
        drive(kf_sched, KF_DATA, KF_PT);
        @(negedge clk);
        expected = exp_q.pop_front();
        vectors++;
        if (plainText !== expected) begin
            miscompares++;
            $display("FAIL kung_fu: got %h expected %h", plainText, expected);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] expected;
        @(negedge clk);
        drive(kf_sched, KF_DATA, KF_PT);
        @(negedge clk);
        expected = exp_q.pop_front();
        vectors++;
        if (plainText !== expected) begin
            miscompares++;
            $display("FAIL b2b_first: got %h expected %h", plainText, expected);
        end
        drive(c1_sched, C1_DATA, C1_PT);
        @(negedge clk);
        expected = exp_q.pop_front();
        vectors++;
        if (plainText !== expected) begin
            miscompares++;
            $display("FAIL b2b_second: got %h expected %h", plainText, expected);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] expected;
        @(negedge clk);
        drive(kf_sched, KF_DATA, KF_PT);
        @(negedge clk);
        expected = exp_q.pop_front();
        vectors++;
        if (plainText !== expected) begin
            miscompares++;
            $display("FAIL pre_reset: got %h expected %h", plainText, expected);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (plainText !== 128'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", plainText, 128'h0);
        end
        @(negedge clk);
        vectors++;
        if (plainText !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_across_edge: got %h expected %h", plainText, 128'h0);
        end
        rst = 1'b0;
        exp_q.push_back(KF_PT);
        @(negedge clk);
        expected = exp_q.pop_front();
        vectors++;
        if (plainText !== expected) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", plainText, expected);
        end
    endtask

    task automatic test_key_change();
        logic [127:0] expected;
        @(negedge clk);
        drive(c1_sched, C1_DATA, model_decrypt(c1_sched, C1_DATA));
        @(negedge clk);
        expected = exp_q.pop_front();
        vectors++;
        if (plainText !== expected) begin
            miscompares++;
            $display("FAIL key_change_before: got %h expected %h", plainText, expected);
        end
        drive(kf_sched, C1_DATA, model_decrypt(kf_sched, C1_DATA));
        @(negedge clk);
        expected = exp_q.pop_front();
        vectors++;
        if (plainText !== expected) begin
            miscompares++;
            $display("FAIL key_change_after: got %h expected %h", plainText, expected);
        end
    endtask

    task automatic test_random();
        logic [127:0]  expected;
        logic [1407:0] k;
        logic [127:0]  d;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            if (i > 0) begin
                @(negedge clk);
                expected = exp_q.pop_front();
                vectors++;
                if (plainText !== expected) begin
                    miscompares++;
                    $display("FAIL random_%0d: got %h expected %h", i - 1, plainText, expected);
                end
            end
            for (int w = 0; w < 44; w++) k[32*w +: 32] = $urandom();
            for (int w = 0; w < 4; w++)  d[32*w +: 32] = $urandom();
            drive(k, d, model_decrypt(k, d));
        end
        @(negedge clk);
        expected = exp_q.pop_front();
        vectors++;
        if (plainText !== expected) begin
            miscompares++;
            $display("FAIL random_999: got %h expected %h", plainText, expected);
        end
    endtask

    initial begin
        rst  = 1'b1;
        key  = '0;
        data = '0;
        init_tables();
        c1_sched = expand_key(C1_KEY);
        kf_sched = expand_key(KF_KEY);

        test_reset();
        test_fips_c1();
        test_kung_fu();
        test_back_to_back();
        test_async_reset();
        test_key_change();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
